mc_pre_feeder: RTL and testbench
================================

# mc_pre_feeder

Downstream chroma stage of motion compensation. Once chroma prediction for one component has been packed into the FME prediction buffer as 8x8 words, this block reads back the 32x32 prediction in z-scan order. It forwards each word to reconstruction on the pre_* interface, one 16x16 group at a time. Before releasing the next group it waits for reconstruction to acknowledge with `rec_done_i`.

## Interface
- `PIXEL_WIDTH`, default 8: bits per pixel.
- `SEL_U`, default 2'b10: pre_sel code for the Cb component.
- `SEL_V`, default 2'b11: pre_sel code for the Cr component.
- `clk`  in  1  clock.
- `rstn`  in  1  reset: asynchronous, active-low.
- `start_i`  in  1  single-cycle launch pulse.
- `sel_i`  in  2  component select; sampled with `start_i`.
- `done_o`  out  1  single-cycle completion pulse.
- `fme_rd_ena_o`  out  1  prediction-buffer read strobe.
- `fme_rd_siz_o`  out  2  read size; constant `SIZE_08`.
- `fme_rd_4x4_x_o`  out  4  x coordinate of the 8x8 block, in 4x4 units.
- `fme_rd_4x4_y_o`  out  4  y coordinate of the 8x8 block, in 4x4 units.
- `fme_rd_idx_o`  out  5  row index: 0 for the top half, 4 for the bottom half.
- `fme_rd_dat_i`  in  32*PIXEL_WIDTH  read data; 4 rows x 8 pixels, row 0 in the MSBs.
- `pre_en_o`  out  1  prediction write strobe to reconstruction.
- `pre_sel_o`  out  2  component select latched at start.
- `pre_size_o`  out  2  write size; constant `SIZE_08`.
- `pre_4x4_x_o`, `pre_4x4_y_o`  out  4 each  block coordinates, same encoding as the read side.
- `pre_data_o`  out  32*PIXEL_WIDTH  prediction pixels.
- `rec_done_i`  in  1  reconstruction acknowledge for the current 16x16 group.

## Operation
- **States:** IDLE, READ, DRAIN, WAIT_REC, FIN.
- **Word counter `w[4:0]`:**
  - one 32x32 component is 32 words.
  - group g = w[4:3], block b = w[4:1], half h = w[0].
- **Address mapping:**
  - 4x4_x = {b[2], b[0], 1'b0}.
  - 4x4_y = {b[3], b[1], 1'b0}.
  - idx = {h, 2'b00}.
- **IDLE:**
  - on `start_i` with sel_i equal to SEL_U or SEL_V: latch sel, clear w, go to READ.
  - on `start_i` with any other sel: go to FIN and make no transfers.
  - `start_i` is ignored outside IDLE.
- **READ:**
  - assert `fme_rd_ena_o` every cycle with the address of w, then increment w.
  - after the eighth read of the group (w[2:0]=7), go to DRAIN.
- **DRAIN:** wait until the group's last `pre_en_o` has been issued, then go to WAIT_REC.
- **WAIT_REC:**
  - `rec_done_i` is sampled only in this state; pulses in any other state are ignored.
  - on `rec_done_i`, go to READ if g < 3, otherwise go to FIN.
- **FIN:** assert `done_o` for one cycle, return to IDLE.
- **Write path:**
  - read address and strobe go through two register stages to `pre_*`.
  - `pre_data_o` is `fme_rd_dat_i` registered in the cycle after the read.
  - `pre_data_o` holds its value when `pre_en_o` is low.
- **Reset:**
  - all outputs are 0, except the constant size fields, which always equal `SIZE_08`.
  - FSM goes to IDLE; w and the latched sel are cleared.
  - reset mid-operation aborts the transfer and issues no `done_o`.

## Timing
- Cycle 0: `start_i` sampled.
- Cycles 1–8: `fme_rd_ena_o` high, words 0–7.
- `fme_rd_dat_i` is valid one cycle after each `fme_rd_ena_o`.
- `pre_en_o` follows its read strobe by exactly 2 cycles: cycles 3–10, coordinates identical to the read.
- WAIT_REC is entered at cycle 11.
- If `rec_done_i` arrives in cycle N, the next group's first read is in cycle N+1.
- After the fourth acknowledge at cycle N, `done_o` is high in cycle N+1.
- Best case, with `rec_done_i` held high: 4 x 11 + 1 = 45 cycles from start to `done_o`.
- Invalid sel: `done_o` in cycle 2.
- Never more than 8 words are in flight ahead of an acknowledge.

## Structure
- Shared package (enc_defines) holds `SIZE_08`, `PIXEL_WIDTH`, `SEL_U`, `SEL_V` and the FSM state encoding.
- One sub-module: `mc_pre_zaddr`.
  - combinational mapping from w[4:0] to {4x4_x, 4x4_y, idx}.
  - reused by any future luma feeder.
- The FSM and the 2-stage delay pipeline live in the top module.

## Test plan
- **Nominal U:** sel 2'b10, buffer word at (x,y,idx) preloaded with a unique tag, `rec_done_i` held high.
  - 32 `pre_en_o`, in order x/y (0,0),(2,0),(0,2),(2,2),(4,0)… with idx 0 then 4.
  - data tags match, `pre_sel_o`=2'b10, `done_o` at cycle 45.
- **Acknowledge stall:** hold `rec_done_i` low 20 cycles after each group.
  - no `fme_rd_ena_o` while in WAIT_REC.
  - next read exactly 1 cycle after `rec_done_i`.
  - `done_o` delayed by 80 cycles.
- **Spurious acknowledge:** pulse `rec_done_i` during READ of group 0.
  - ignored; block still waits in WAIT_REC for a fresh pulse.
- **Invalid sel:** sel 2'b00 → no reads, no writes, `done_o` at cycle 2; `start_i` at cycle 1 is ignored.
- **Mid-run reset:** assert `rstn` low during group 2 READ.
  - all outputs 0 immediately.
  - after release, a new start with sel 2'b11 completes normally with `pre_sel_o`=2'b11.
- **Busy start:** pulse `start_i` with sel 2'b11 during a U run → no effect; `pre_sel_o` remains 2'b10.

Source files
------------

// File: rtl/enc_defines.sv
// rtl/enc_defines.sv - shared encoder constants, FSM encoding and block-address type
package enc_defines;

  localparam int         PIXEL_WIDTH = 8;
  localparam logic [1:0] SIZE_08     = 2'b01;
  localparam logic [1:0] SEL_U       = 2'b10;
  localparam logic [1:0] SEL_V       = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WAIT_REC,
    ST_FIN
  } pre_state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] idx;
  } zaddr_t;

endpackage

// File: rtl/mc_pre_zaddr.sv
// rtl/mc_pre_zaddr.sv - z-scan word counter to 8x8 block address and half-row index
module mc_pre_zaddr (
  input  logic [4:0] i_w,
  output logic [3:0] o_x,
  output logic [3:0] o_y,
  output logic [4:0] o_idx
);

  // Block b = w[4:1]: even bits of b walk x, odd bits walk y, in 4x4 units.
  assign o_x   = {1'b0, i_w[3], i_w[1], 1'b0};
  assign o_y   = {1'b0, i_w[4], i_w[2], 1'b0};
  assign o_idx = {2'b00, i_w[0], 2'b00};

endmodule

// File: rtl/mc_pre_feeder.sv
// rtl/mc_pre_feeder.sv - reads a 32x32 chroma prediction in z-scan, feeds reconstruction per 16x16 group
module mc_pre_feeder
  import enc_defines::*;
#(
  parameter int         PIXEL_WIDTH = enc_defines::PIXEL_WIDTH,
  parameter logic [1:0] SEL_U       = enc_defines::SEL_U,
  parameter logic [1:0] SEL_V       = enc_defines::SEL_V
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start_i,
  input  logic [1:0]                sel_i,
  output logic                      done_o,
  output logic                      fme_rd_ena_o,
  output logic [1:0]                fme_rd_siz_o,
  output logic [3:0]                fme_rd_4x4_x_o,
  output logic [3:0]                fme_rd_4x4_y_o,
  output logic [4:0]                fme_rd_idx_o,
  input  logic [32*PIXEL_WIDTH-1:0] fme_rd_dat_i,
  output logic                      pre_en_o,
  output logic [1:0]                pre_sel_o,
  output logic [1:0]                pre_size_o,
  output logic [3:0]                pre_4x4_x_o,
  output logic [3:0]                pre_4x4_y_o,
  output logic [32*PIXEL_WIDTH-1:0] pre_data_o,
  input  logic                      rec_done_i
);

  pre_state_t                r_state;
  pre_state_t                w_state_nxt;
  logic [4:0]                r_w;
  logic [1:0]                r_sel;
  logic                      r_rej;
  logic                      r_done;
  logic                      w_done_nxt;
  logic                      w_sel_ok;
  zaddr_t                    w_addr;
  logic                      r_s1_en;
  logic                      r_s2_en;
  zaddr_t                    r_s1_addr;
  zaddr_t                    r_s2_addr;
  logic [32*PIXEL_WIDTH-1:0] r_data;

  mc_pre_zaddr u_zaddr (
    .i_w   (r_w),
    .o_x   (w_addr.x),
    .o_y   (w_addr.y),
    .o_idx (w_addr.idx)
  );

  assign w_sel_ok = (sel_i == SEL_U) || (sel_i == SEL_V);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = w_sel_ok ? ST_READ : ST_FIN;
      end
      ST_READ: begin
        if (r_w[2:0] == 3'd7) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_s1_en) w_state_nxt = ST_WAIT_REC;
      end
      ST_WAIT_REC: begin
        // w has already wrapped to 0 once the fourth group has been read
        if (rec_done_i) begin
          if (r_w == 5'd0) begin
            w_state_nxt = ST_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_READ;
          end
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = r_rej;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_w     <= 5'd0;
      r_sel   <= 2'b00;
      r_rej   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (r_state == ST_IDLE && start_i) begin
        r_w   <= 5'd0;
        r_rej <= !w_sel_ok;
        if (w_sel_ok) r_sel <= sel_i;
      end else if (r_state == ST_READ) begin
        r_w <= r_w + 5'd1;
      end
    end
  end

  // Two-stage address/strobe delay; read data lands in the second stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_en   <= 1'b0;
      r_s2_en   <= 1'b0;
      r_s1_addr <= '0;
      r_s2_addr <= '0;
      r_data    <= '0;
    end else begin
      r_s1_en   <= (r_state == ST_READ);
      r_s1_addr <= w_addr;
      r_s2_en   <= r_s1_en;
      r_s2_addr <= r_s1_addr;
      if (r_s1_en) r_data <= fme_rd_dat_i;
    end
  end

  assign done_o         = r_done;
  assign fme_rd_ena_o   = (r_state == ST_READ);
  assign fme_rd_siz_o   = SIZE_08;
  assign fme_rd_4x4_x_o = w_addr.x;
  assign fme_rd_4x4_y_o = w_addr.y;
  assign fme_rd_idx_o   = w_addr.idx;
  assign pre_en_o       = r_s2_en;
  assign pre_sel_o      = r_sel;
  assign pre_size_o     = SIZE_08;
  assign pre_4x4_x_o    = r_s2_addr.x;
  assign pre_4x4_y_o    = r_s2_addr.y;
  assign pre_data_o     = r_data;

endmodule

// File: tb/tb_mc_pre_feeder.sv
// tb/tb_mc_pre_feeder.sv - self-checking bench for mc_pre_feeder against a z-scan transfer model
module tb_mc_pre_feeder;

  localparam logic [1:0] SZ8 = enc_defines::SIZE_08;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   sel_i = 2'b00;
  logic         done_o;
  logic         fme_rd_ena_o;
  logic [1:0]   fme_rd_siz_o;
  logic [3:0]   fme_rd_4x4_x_o;
  logic [3:0]   fme_rd_4x4_y_o;
  logic [4:0]   fme_rd_idx_o;
  logic [255:0] fme_rd_dat_i = '0;
  logic         pre_en_o;
  logic [1:0]   pre_sel_o;
  logic [1:0]   pre_size_o;
  logic [3:0]   pre_4x4_x_o;
  logic [3:0]   pre_4x4_y_o;
  logic [255:0] pre_data_o;
  logic         rec_done_i = 1'b0;

  mc_pre_feeder dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (start_i),
    .sel_i          (sel_i),
    .done_o         (done_o),
    .fme_rd_ena_o   (fme_rd_ena_o),
    .fme_rd_siz_o   (fme_rd_siz_o),
    .fme_rd_4x4_x_o (fme_rd_4x4_x_o),
    .fme_rd_4x4_y_o (fme_rd_4x4_y_o),
    .fme_rd_idx_o   (fme_rd_idx_o),
    .fme_rd_dat_i   (fme_rd_dat_i),
    .pre_en_o       (pre_en_o),
    .pre_sel_o      (pre_sel_o),
    .pre_size_o     (pre_size_o),
    .pre_4x4_x_o    (pre_4x4_x_o),
    .pre_4x4_y_o    (pre_4x4_y_o),
    .pre_data_o     (pre_data_o),
    .rec_done_i     (rec_done_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           c;
    logic [3:0]   x;
    logic [3:0]   y;
    logic [4:0]   idx;
    logic [1:0]   sel;
    logic [1:0]   siz;
    logic [255:0] d;
  } ev_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  ev_t          rdq[$];
  ev_t          prq[$];
  int           dnq[$];
  logic [255:0] mem [16][16][2];
  logic         rd_pend = 1'b0;
  logic [3:0]   rd_x, rd_y;
  logic         rd_h;
  ev_t          mon_e;

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Prediction buffer: data appears one cycle after the read strobe, garbage otherwise.
  always @(negedge clk) begin
    rd_pend = fme_rd_ena_o;
    rd_x    = fme_rd_4x4_x_o;
    rd_y    = fme_rd_4x4_y_o;
    rd_h    = fme_rd_idx_o[2];
    if (fme_rd_ena_o) begin
      mon_e = '{cyc, fme_rd_4x4_x_o, fme_rd_4x4_y_o, fme_rd_idx_o, 2'b00, fme_rd_siz_o, '0};
      rdq.push_back(mon_e);
    end
    if (pre_en_o) begin
      mon_e = '{cyc, pre_4x4_x_o, pre_4x4_y_o, 5'd0, pre_sel_o, pre_size_o, pre_data_o};
      prq.push_back(mon_e);
    end
    if (done_o) dnq.push_back(cyc);
  end

  always @(posedge clk) begin
    #1;
    fme_rd_dat_i = rd_pend ? mem[rd_x][rd_y][rd_h] : rnd256();
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {done_o, fme_rd_ena_o, fme_rd_4x4_x_o, fme_rd_4x4_y_o, fme_rd_idx_o,
                         pre_en_o, pre_sel_o, pre_4x4_x_o, pre_4x4_y_o, pre_data_o}, '0);
    chk({tag, "_sizes"}, {fme_rd_siz_o, pre_size_o}, {SZ8, SZ8});
  endtask

  task automatic run_job(input logic [1:0] sel, input int stall, input int spur_at,
                         input int busy_at, input logic [1:0] busy_sel, input int rst_at);
    int   c0, per, exp_done, n, nrd, g, q, w, ex, ey, rc;
    logic valid, ack;
    valid    = (sel == 2'b10) || (sel == 2'b11);
    per      = 11 + stall;
    exp_done = valid ? 45 + 4 * stall : 2;
    n        = exp_done + 6;
    c0       = 0;
    rdq.delete(); prq.delete(); dnq.delete();
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
      start_i = (k == 0) || (k == busy_at);
      sel_i   = (k == 0) ? sel : busy_sel;
      ack     = (stall == 0) && (k > 0);
      for (int gg = 0; gg < 4; gg++) if (k == 11 + gg * per + stall) ack = 1'b1;
      if (k == spur_at) ack = 1'b1;
      rec_done_i = ack;
      if (k == rst_at) begin
        rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        start_i = 1'b0; rec_done_i = 1'b0;
        rdq.delete(); prq.delete(); dnq.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_quiet", {rdq.size(), prq.size(), dnq.size()}, '0);
        return;
      end
    end
    start_i = 1'b0; rec_done_i = 1'b0;

    nrd = valid ? 32 : 0;
    chk("rd_count", rdq.size(), nrd);
    chk("pre_count", prq.size(), nrd);
    for (int i = 0; i < nrd && i < rdq.size() && i < prq.size(); i++) begin
      w  = i;
      g  = w / 8;
      q  = (w / 2) % 4;
      ex = 4 * (g % 2) + 2 * (q % 2);
      ey = 4 * (g / 2) + 2 * (q / 2);
      rc = 1 + g * per + (w % 8);
      chk($sformatf("rd%0d", i), {rdq[i].c - c0, rdq[i].x, rdq[i].y, rdq[i].idx, rdq[i].siz},
          {rc, 4'(ex), 4'(ey), 5'(4 * (w % 2)), SZ8});
      chk($sformatf("pre%0d", i), {prq[i].c - c0, prq[i].x, prq[i].y, prq[i].sel, prq[i].siz},
          {rc + 2, 4'(ex), 4'(ey), sel, SZ8});
      chk($sformatf("dat%0d", i), prq[i].d, mem[ex][ey][w % 2]);
    end
    chk("done_count", dnq.size(), 1);
    if (dnq.size() > 0) chk("done_cycle", dnq[0] - c0, exp_done);
  endtask

  initial begin
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int h = 0; h < 2; h++) mem[x][y][h] = rnd256();

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_job(2'b10, 0, -1, 15, 2'b11, -1);
    chk("busy_sel_kept", pre_sel_o, 2'b10);
    run_job(2'b10, 20, -1, -1, 2'b00, -1);
    run_job(2'b10, 5, 4, -1, 2'b00, -1);
    run_job(2'b00, 0, -1, 1, 2'b10, -1);
    chk("inval_sel_kept", pre_sel_o, 2'b10);
    run_job(2'b10, 0, -1, -1, 2'b00, 25);
    chk("post_rst_sel", pre_sel_o, 2'b00);
    run_job(2'b11, 0, -1, -1, 2'b00, -1);
    chk("v_sel", pre_sel_o, 2'b11);
    run_job(2'b11, int'($urandom_range(1, 9)), int'($urandom_range(1, 8)), -1, 2'b00, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
